multicycle_ctrl: RTL

Multi-cycle sequencer for the RV64I datapath (regfile, ALU, ImmGen, ALUcontrol, branch adder). It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives every datapath strobe and the instruction- and data-memory request handshakes. It replaces the single-cycle `Control` decode for the R-format, ld, sd and beq subset, and enters a sticky FAULT on an illegal opcode or a memory timeout.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/wait_timer.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV64I sequencer.
package ctrl_pkg;

  // Sequencer states; encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  // Supported major opcodes (instr[6:0]).
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Encodings understood by ALUcontrol.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Bundle of every datapath strobe driven by the sequencer.
  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       ab_load;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       aluout_load;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       retired;
    logic       fault;
  } ctrl_t;

  // True for the opcodes this sequencer knows how to step through.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_LD, OP_SD, OP_BEQ: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait watchdog: counts stalled cycles and flags when the limit is hit.
module wait_timer
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] count_r;

  // Stall counter: cleared on any state change, saturates so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (inc && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // A limit of zero means the watchdog never fires.
  always_comb begin
    if (LIMIT == 8'd0) begin
      expired = 1'b0;
    end else begin
      expired = (count_r == LIMIT);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV64I datapath (R-format, ld, sd, beq).
// Steps FETCH/DECODE/EXEC/MEM/WB, drives all datapath strobes and the
// memory handshakes, and locks into FAULT on an illegal opcode or timeout.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ab_load,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       aluout_load,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       retired,
  output logic       fault,
  output logic [2:0] state
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [6:0] op_q;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;
  logic       inc_s;
  logic       clr_s;
  logic       expired_s;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr_s),
    .inc     (inc_s),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Opcode capture in DECODE so later IR changes cannot disturb the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= 7'd0;
    end else if (state_r == DECODE) begin
      op_q <= opcode;
    end else begin
      op_q <= op_q;
    end
  end

  // Next-state and strobe decode from the current state and latched opcode.
  always_comb begin
    state_nxt_s = state_r;
    ctrl_s      = '0;
    inc_s       = 1'b0;
    case (state_r)
      FETCH: begin
        ctrl_s.imem_req = 1'b1;
        if (imem_ready) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          ctrl_s.pc_src   = 1'b0;
          state_nxt_s     = DECODE;
        end else begin
          inc_s = 1'b1;
          if (expired_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = FETCH;
          end
        end
      end
      DECODE: begin
        ctrl_s.ab_load = 1'b1;
        if (is_legal_op(opcode)) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = FAULT;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R: begin
            ctrl_s.alu_op      = ALUOP_FUNCT;
            ctrl_s.alu_src     = 1'b0;
            ctrl_s.aluout_load = 1'b1;
            state_nxt_s        = WB;
          end
          OP_LD, OP_SD: begin
            ctrl_s.alu_op      = ALUOP_ADD;
            ctrl_s.alu_src     = 1'b1;
            ctrl_s.aluout_load = 1'b1;
            state_nxt_s        = MEM;
          end
          OP_BEQ: begin
            ctrl_s.alu_op  = ALUOP_SUB;
            ctrl_s.alu_src = 1'b0;
            if (zero) begin
              // Branch target is old_pc + (imm << 1) from the branch adder.
              ctrl_s.pc_write = 1'b1;
              ctrl_s.pc_src   = 1'b1;
            end else begin
              ctrl_s.pc_write = 1'b0;
              ctrl_s.pc_src   = 1'b0;
            end
            ctrl_s.retired = 1'b1;
            state_nxt_s    = FETCH;
          end
          default: begin
            // op_q was vetted in DECODE; anything else is corruption.
            state_nxt_s = FAULT;
          end
        endcase
      end
      MEM: begin
        if (op_q == OP_LD) begin
          ctrl_s.mem_read = 1'b1;
        end else if (op_q == OP_SD) begin
          ctrl_s.mem_write = 1'b1;
        end else begin
          ctrl_s.mem_read  = 1'b0;
          ctrl_s.mem_write = 1'b0;
        end
        if ((op_q != OP_LD) && (op_q != OP_SD)) begin
          state_nxt_s = FAULT;
        end else if (dmem_ready) begin
          // Ready wins over a simultaneous timeout.
          if (op_q == OP_LD) begin
            state_nxt_s = WB;
          end else begin
            ctrl_s.retired = 1'b1;
            state_nxt_s    = FETCH;
          end
        end else begin
          inc_s = 1'b1;
          if (expired_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = MEM;
          end
        end
      end
      WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = (op_q == OP_LD);
        ctrl_s.retired    = 1'b1;
        state_nxt_s       = FETCH;
      end
      FAULT: begin
        ctrl_s.fault = 1'b1;
        state_nxt_s  = FAULT;
      end
      default: begin
        state_nxt_s = FAULT;
      end
    endcase
  end

  // Wait counter restarts whenever the sequencer moves on.
  assign clr_s = (state_nxt_s != state_r);

  // While reset is held every output is forced low, dropping any request.
  always_comb begin
    if (reset) begin
      ctrl_out_s = '0;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign imem_req    = ctrl_out_s.imem_req;
  assign ir_write    = ctrl_out_s.ir_write;
  assign pc_write    = ctrl_out_s.pc_write;
  assign pc_src      = ctrl_out_s.pc_src;
  assign ab_load     = ctrl_out_s.ab_load;
  assign alu_src     = ctrl_out_s.alu_src;
  assign alu_op      = ctrl_out_s.alu_op;
  assign aluout_load = ctrl_out_s.aluout_load;
  assign mem_read    = ctrl_out_s.mem_read;
  assign mem_write   = ctrl_out_s.mem_write;
  assign mem_to_reg  = ctrl_out_s.mem_to_reg;
  assign reg_write   = ctrl_out_s.reg_write;
  assign retired     = ctrl_out_s.retired;
  assign fault       = ctrl_out_s.fault;
  assign state       = reset ? 3'd0 : state_r;

endmodule
